// File: rtl/branch_resolve_controller.sv
// Branch resolve controller: queues ID-stage predictions, checks them against EX outcomes,
// and produces predictor training strobes, mispredict flush/redirect, and branch statistics.
module branch_resolve_controller #(
   parameter int DEPTH = 2,
   parameter int CNTW  = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            BranchInstructExists_ID,
   input  logic            Prediction_ID,
   input  logic            Stall_ID,
   input  logic [31:0]     PCPlus4_ID,
   input  logic [31:0]     BranchTarget_ID,
   input  logic            BranchInstructExists_EX,
   input  logic            BranchDecision_EX,
   output logic            Flush,
   output logic [31:0]     RedirectPC,
   output logic            UpdateValid,
   output logic            UpdateTaken,
   output logic            QueueFull,
   output logic            Underflow,
   output logic            Overflow,
   output logic [CNTW-1:0] BranchCount,
   output logic [CNTW-1:0] MispredictCount
);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic        pred;
      logic [31:0] pcPlus4;
      logic [31:0] target;
   } entryT;

   entryT         q [DEPTH];
   entryT         head;
   logic [PW-1:0] rdPtr, wrPtr;
   logic [PW:0]   occ, occNext;
   logic          pop, mispredict, flushNow, pushReq, push;

   always_comb begin
      head       = q[rdPtr];
      pop        = BranchInstructExists_EX && (occ != '0);
      mispredict = pop && (head.pred != BranchDecision_EX);
      flushNow   = mispredict;
      pushReq    = BranchInstructExists_ID && !Stall_ID && !flushNow;
      // A full queue still accepts a push when the head leaves in the same cycle.
      push       = pushReq && (!QueueFull || pop);
   end

   always_comb begin
      occNext = occ;
      if (flushNow)
         occNext = '0;
      else if (push && !pop)
         occNext = occ + (PW+1)'(1);
      else if (pop && !push)
         occNext = occ - (PW+1)'(1);
   end

   // Entry contents need no reset; occupancy decides what is valid.
   always_ff @(posedge Clock) begin
      if (push)
         q[wrPtr] <= '{pred: Prediction_ID, pcPlus4: PCPlus4_ID, target: BranchTarget_ID};
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rdPtr           <= '0;
         wrPtr           <= '0;
         occ             <= '0;
         QueueFull       <= 1'b0;
         Flush           <= 1'b0;
         RedirectPC      <= 32'h0;
         UpdateValid     <= 1'b0;
         UpdateTaken     <= 1'b0;
         Underflow       <= 1'b0;
         Overflow        <= 1'b0;
         BranchCount     <= '0;
         MispredictCount <= '0;
      end else begin
         occ         <= occNext;
         QueueFull   <= (occNext == (PW+1)'(DEPTH));
         Flush       <= flushNow;
         UpdateValid <= pop;
         UpdateTaken <= pop && BranchDecision_EX;

         // Younger entries are wrong-path on a mispredict: collapse the queue behind the head.
         if (flushNow) begin
            rdPtr <= rdPtr + PW'(1);
            wrPtr <= rdPtr + PW'(1);
         end else begin
            if (pop)  rdPtr <= rdPtr + PW'(1);
            if (push) wrPtr <= wrPtr + PW'(1);
         end

         if (flushNow)
            RedirectPC <= BranchDecision_EX ? head.target : head.pcPlus4;

         if (pop && BranchCount != '1)
            BranchCount <= BranchCount + CNTW'(1);
         if (mispredict && MispredictCount != '1)
            MispredictCount <= MispredictCount + CNTW'(1);

         if (BranchInstructExists_EX && occ == '0)
            Underflow <= 1'b1;
         if (pushReq && QueueFull && !pop)
            Overflow <= 1'b1;
      end
   end
endmodule
